lsu_mem_arbiter: RTL and testbench

- Shares one external data-memory port between NUM_CONSUMERS load/store units (one per thread) in a core.
- Accepts per-consumer read/write requests and grants one at a time with round-robin fairness.
- Runs the memory valid/ready handshake and returns read data and completion to the granted consumer.
- Sits between the per-thread LSUs and the memory interface.

---
 rtl/lsu_mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_lsu_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_arbiter.sv
// lsu_mem_arbiter
// Shares a single external data-memory port between NUM_CONSUMERS per-thread load/store units.
// Requests are granted one at a time in round-robin order. The memory valid/ready handshake is
// run on behalf of the granted consumer. Completion and read data are then relayed back to it.
//
// Ports
//   clock, reset                   clock (rising edge) and async active-low reset
//   consumer_read_valid/address    per-consumer read request (flattened address vector)
//   consumer_read_ready/data       per-consumer read completion and returned data
//   consumer_write_valid/address   per-consumer write request
//   consumer_write_data            per-consumer write data (flattened)
//   consumer_write_ready           per-consumer write completion
//   mem_read_valid/address         read request to memory
//   mem_read_ready/data            read completion and data from memory
//   mem_write_valid/address/data   write request to memory
//   mem_write_ready                write completion from memory
// All outputs come straight from flops.
module lsu_mem_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int unsigned IdBits = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IdBits-1:0] LastId = IdBits'(NUM_CONSUMERS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReadWaiting,
    StWriteWaiting,
    StReadRelaying,
    StWriteRelaying
  } state_e;

  state_e                   state_q, state_d;
  logic [IdBits-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdBits-1:0]        grant_id_q, grant_id_d;
  logic                     mem_read_valid_q, mem_read_valid_d;
  logic [ADDR_BITS-1:0]     mem_read_address_q, mem_read_address_d;
  logic                     mem_write_valid_q, mem_write_valid_d;
  logic [ADDR_BITS-1:0]     mem_write_address_q, mem_write_address_d;
  logic [DATA_BITS-1:0]     mem_write_data_q, mem_write_data_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d;
  logic [NUM_CONSUMERS-1:0] wr_ready_q, wr_ready_d;
  logic [DATA_BITS-1:0]     rd_data_q [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     rd_data_d [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]     rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]     wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]     wr_data [NUM_CONSUMERS];

  logic                     pick_found;
  logic [IdBits-1:0]        pick_id;
  logic [IdBits-1:0]        cand;
  logic [IdBits-1:0]        next_ptr;

  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slices
    assign rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  // Round-robin scan starting at rr_ptr; first requester (read or write) wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_CONSUMERS; i++) begin
      cand = IdBits'((32'(rr_ptr_q) + i) % NUM_CONSUMERS);
      if (!pick_found && (consumer_read_valid[cand] || consumer_write_valid[cand])) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign next_ptr = (grant_id_q == LastId) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    state_d             = state_q;
    rr_ptr_d            = rr_ptr_q;
    grant_id_d          = grant_id_q;
    mem_read_valid_d    = mem_read_valid_q;
    mem_read_address_d  = mem_read_address_q;
    mem_write_valid_d   = mem_write_valid_q;
    mem_write_address_d = mem_write_address_q;
    mem_write_data_d    = mem_write_data_q;
    rd_ready_d          = rd_ready_q;
    wr_ready_d          = wr_ready_q;
    rd_data_d           = rd_data_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_id_d = pick_id;
          // A consumer asking for both is served read first; its write waits for a later grant.
          if (consumer_read_valid[pick_id]) begin
            mem_read_valid_d   = 1'b1;
            mem_read_address_d = rd_addr[pick_id];
            state_d            = StReadWaiting;
          end else begin
            mem_write_valid_d   = 1'b1;
            mem_write_address_d = wr_addr[pick_id];
            mem_write_data_d    = wr_data[pick_id];
            state_d             = StWriteWaiting;
          end
        end
      end
      StReadWaiting: begin
        if (mem_read_ready) begin
          mem_read_valid_d      = 1'b0;
          rd_data_d[grant_id_q] = mem_read_data;
          rd_ready_d[grant_id_q] = 1'b1;
          state_d               = StReadRelaying;
        end
      end
      StWriteWaiting: begin
        if (mem_write_ready) begin
          mem_write_valid_d      = 1'b0;
          wr_ready_d[grant_id_q] = 1'b1;
          state_d                = StWriteRelaying;
        end
      end
      StReadRelaying: begin
        if (!consumer_read_valid[grant_id_q]) begin
          rd_ready_d[grant_id_q] = 1'b0;
          rr_ptr_d               = next_ptr;
          state_d                = StIdle;
        end
      end
      StWriteRelaying: begin
        if (!consumer_write_valid[grant_id_q]) begin
          wr_ready_d[grant_id_q] = 1'b0;
          rr_ptr_d               = next_ptr;
          state_d                = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q             <= StIdle;
      rr_ptr_q            <= '0;
      grant_id_q          <= '0;
      mem_read_valid_q    <= 1'b0;
      mem_read_address_q  <= '0;
      mem_write_valid_q   <= 1'b0;
      mem_write_address_q <= '0;
      mem_write_data_q    <= '0;
      rd_ready_q          <= '0;
      wr_ready_q          <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      state_q             <= state_d;
      rr_ptr_q            <= rr_ptr_d;
      grant_id_q          <= grant_id_d;
      mem_read_valid_q    <= mem_read_valid_d;
      mem_read_address_q  <= mem_read_address_d;
      mem_write_valid_q   <= mem_write_valid_d;
      mem_write_address_q <= mem_write_address_d;
      mem_write_data_q    <= mem_write_data_d;
      rd_ready_q          <= rd_ready_d;
      wr_ready_q          <= wr_ready_d;
      rd_data_q           <= rd_data_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_write_ready = wr_ready_q;
  assign mem_read_valid       = mem_read_valid_q;
  assign mem_read_address     = mem_read_address_q;
  assign mem_write_valid      = mem_write_valid_q;
  assign mem_write_address    = mem_write_address_q;
  assign mem_write_data       = mem_write_data_q;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Self-checking bench for lsu_mem_arbiter. The consumers and the memory are modelled at the
// transaction level. Per grant, the expected winner comes from a round-robin scan over the
// outstanding requests. The memory address/data, relay timing and returned data are then
// checked against the bench's own record of what each consumer asked for.
module tb_lsu_mem_arbiter;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   crv, cwv;
  logic [N*A-1:0] cra, cwa;
  logic [N*D-1:0] cwd;
  logic [N-1:0]   crr, cwr;
  logic [N*D-1:0] crd;
  logic           mrv, mwv, mrr, mwr;
  logic [A-1:0]   mra, mwa;
  logic [D-1:0]   mrd, mwd;

  lsu_mem_arbiter #(
    .NUM_CONSUMERS(N),
    .ADDR_BITS    (A),
    .DATA_BITS    (D)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .consumer_read_valid   (crv),
    .consumer_read_address (cra),
    .consumer_read_ready   (crr),
    .consumer_read_data    (crd),
    .consumer_write_valid  (cwv),
    .consumer_write_address(cwa),
    .consumer_write_data   (cwd),
    .consumer_write_ready  (cwr),
    .mem_read_valid        (mrv),
    .mem_read_address      (mra),
    .mem_read_ready        (mrr),
    .mem_read_data         (mrd),
    .mem_write_valid       (mwv),
    .mem_write_address     (mwa),
    .mem_write_data        (mwd),
    .mem_write_ready       (mwr)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit           pend_rd [N];
  bit           pend_wr [N];
  logic [A-1:0] rd_addr_m [N];
  logic [A-1:0] wr_addr_m [N];
  logic [D-1:0] wr_data_m [N];
  logic [D-1:0] exp_rdata [N];
  int           rr_m;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  function automatic logic [N*D-1:0] exp_flat();
    logic [N*D-1:0] v;
    for (int i = 0; i < N; i++) v[i*D +: D] = exp_rdata[i];
    return v;
  endfunction

  task automatic drive_consumers();
    for (int i = 0; i < N; i++) begin
      crv[i]         = pend_rd[i];
      cwv[i]         = pend_wr[i];
      cra[i*A +: A]  = rd_addr_m[i];
      cwa[i*A +: A]  = wr_addr_m[i];
      cwd[i*D +: D]  = wr_data_m[i];
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      pend_rd[i]   = 1'b0;
      pend_wr[i]   = 1'b0;
      rd_addr_m[i] = '0;
      wr_addr_m[i] = '0;
      wr_data_m[i] = '0;
      exp_rdata[i] = '0;
    end
    rr_m = 0;
  endtask

  task automatic check_invariants();
    check_eq("one_ready", 64'($countones({crr | cwr}) <= 1), 1);
    check_eq("mem_excl", 64'(mrv && mwv), 0);
  endtask

  // One full grant: arbitration edge, lat memory edges, relay of hold extra cycles, release.
  // data < 0 picks random read data; add_rd >= 0 raises a new read from that consumer mid-flight.
  task automatic serve_one(input int lat, input int hold, input bit withdraw, input int data,
                           input int add_rd, input logic [A-1:0] add_addr);
    int           w;
    bit           is_rd;
    logic [A-1:0] ea;
    logic [D-1:0] ed;
    logic [D-1:0] d;
    w = -1;
    for (int i = 0; i < N; i++) begin
      int c;
      c = (rr_m + i) % N;
      if (w < 0 && (pend_rd[c] || pend_wr[c])) w = c;
    end
    if (w < 0) begin
      tick();
      check_eq("idle_valid", {mrv, mwv}, 0);
      return;
    end
    is_rd = pend_rd[w];
    ea    = is_rd ? rd_addr_m[w] : wr_addr_m[w];
    ed    = wr_data_m[w];

    tick();
    check_eq("grant_rv", mrv, is_rd);
    check_eq("grant_wv", mwv, !is_rd);
    check_eq("grant_addr", is_rd ? mra : mwa, ea);
    if (!is_rd) check_eq("grant_wdata", mwd, ed);
    check_eq("grant_rdy", {crr, cwr}, 0);

    if (add_rd >= 0) begin
      pend_rd[add_rd]   = 1'b1;
      rd_addr_m[add_rd] = add_addr;
      drive_consumers();
    end

    for (int j = 1; j < lat; j++) begin
      // Memory-side address/data must not follow the consumer once latched.
      if ($urandom_range(1) == 1) begin
        if (is_rd) cra[w*A +: A] = A'($urandom);
        else begin
          cwa[w*A +: A] = A'($urandom);
          cwd[w*D +: D] = D'($urandom);
        end
      end
      tick();
      check_eq("wait_valid", is_rd ? mrv : mwv, 1);
      check_eq("wait_addr", is_rd ? mra : mwa, ea);
      if (!is_rd) check_eq("wait_wdata", mwd, ed);
      check_eq("wait_rdy", {crr, cwr}, 0);
      check_invariants();
    end

    if (withdraw) begin
      if (is_rd) pend_rd[w] = 1'b0;
      else pend_wr[w] = 1'b0;
      drive_consumers();
    end

    d = (data >= 0) ? D'(data) : D'($urandom);
    if (is_rd) begin
      mrr = 1'b1;
      mrd = d;
    end else begin
      mwr = 1'b1;
    end
    tick();
    mrr = 1'b0;
    mwr = 1'b0;
    mrd = D'($urandom);
    if (is_rd) exp_rdata[w] = d;
    check_eq("done_valid", {mrv, mwv}, 0);
    check_eq("done_rrdy", crr, is_rd ? onehot(w) : '0);
    check_eq("done_wrdy", cwr, is_rd ? '0 : onehot(w));
    check_eq("done_rdata", crd, exp_flat());

    if (!withdraw) begin
      for (int h = 0; h < hold; h++) begin
        tick();
        check_eq("relay_rrdy", crr, is_rd ? onehot(w) : '0);
        check_eq("relay_wrdy", cwr, is_rd ? '0 : onehot(w));
        check_eq("relay_valid", {mrv, mwv}, 0);
      end
    end

    if (is_rd) pend_rd[w] = 1'b0;
    else pend_wr[w] = 1'b0;
    drive_consumers();
    tick();
    check_eq("release_rdy", {crr, cwr}, 0);
    check_eq("release_rdata", crd, exp_flat());
    check_invariants();
    rr_m = (w + 1) % N;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    reset = 1'b0;
    mrr   = 1'b0;
    mwr   = 1'b0;
    mrd   = '0;

    // Reset held with random inputs: every output stays zero.
    for (int k = 0; k < 5; k++) begin
      crv = N'($urandom);
      cwv = N'($urandom);
      cra = $urandom;
      cwa = $urandom;
      cwd = $urandom;
      mrr = 1'($urandom_range(1));
      mwr = 1'($urandom_range(1));
      mrd = D'($urandom);
      tick();
      check_eq("rst_rdy", {crr, cwr}, 0);
      check_eq("rst_mvalid", {mrv, mwv}, 0);
      check_eq("rst_maddr", {mra, mwa, mwd}, 0);
      check_eq("rst_rdata", crd, 0);
    end
    mrr = 1'b0;
    mwr = 1'b0;
    drive_consumers();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("idle_quiet", {mrv, mwv}, 0);
    end

    // Round-robin: 0, 1, 3 together; 0 re-requests while 3 is served.
    pend_rd[0] = 1'b1; rd_addr_m[0] = 8'h10;
    pend_rd[1] = 1'b1; rd_addr_m[1] = 8'h11;
    pend_rd[3] = 1'b1; rd_addr_m[3] = 8'h13;
    drive_consumers();
    serve_one(1, 1, 1'b0, -1, -1, '0);
    serve_one(1, 1, 1'b0, -1, -1, '0);
    serve_one(1, 1, 1'b0, -1, 0, 8'h30);
    serve_one(1, 0, 1'b0, -1, -1, '0);

    // Single read: consumer 2, address 0x3C, memory answers 0xA5 two cycles after valid.
    pend_rd[2] = 1'b1; rd_addr_m[2] = 8'h3C;
    drive_consumers();
    serve_one(2, 3, 1'b0, 8'hA5, -1, '0);

    // Write path: consumer 1 reads and writes at once; read goes first.
    pend_rd[1] = 1'b1; rd_addr_m[1] = 8'h20;
    pend_wr[1] = 1'b1; wr_addr_m[1] = 8'h10; wr_data_m[1] = 8'h7E;
    drive_consumers();
    serve_one(1, 1, 1'b0, -1, -1, '0);
    serve_one(2, 0, 1'b0, -1, -1, '0);

    // Withdrawal: consumer 0 drops valid while waiting; then 1 must beat 0.
    pend_rd[0] = 1'b1; rd_addr_m[0] = 8'h5A;
    drive_consumers();
    serve_one(3, 0, 1'b1, -1, -1, '0);
    pend_rd[0] = 1'b1; rd_addr_m[0] = 8'h6A;
    pend_rd[1] = 1'b1; rd_addr_m[1] = 8'h6B;
    drive_consumers();
    serve_one(1, 0, 1'b0, -1, -1, '0);
    serve_one(1, 0, 1'b0, -1, -1, '0);

    // Reset mid-write: pointer sits past consumer 1, consumer 2 write is in flight.
    pend_rd[1] = 1'b1; rd_addr_m[1] = 8'h51;
    drive_consumers();
    serve_one(1, 0, 1'b0, -1, -1, '0);
    pend_wr[2] = 1'b1; wr_addr_m[2] = 8'h44; wr_data_m[2] = 8'h99;
    drive_consumers();
    tick();
    check_eq("mid_wv", mwv, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_async_wv", mwv, 0);
    check_eq("mid_async_waddr", {mwa, mwd}, 0);
    check_eq("mid_async_rdata", crd, 0);
    for (int i = 0; i < N; i++) exp_rdata[i] = '0;
    rr_m = 0;
    mwr  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("mid_rst_rdy", {crr, cwr}, 0);
    end
    mwr = 1'b0;
    pend_rd[1] = 1'b1; rd_addr_m[1] = 8'h61;
    drive_consumers();
    reset = 1'b1;
    serve_one(2, 1, 1'b0, -1, -1, '0);
    serve_one(1, 1, 1'b0, -1, -1, '0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend_rd[i] && $urandom_range(2) == 0) begin
          pend_rd[i]   = 1'b1;
          rd_addr_m[i] = A'($urandom);
        end
        if (!pend_wr[i] && $urandom_range(3) == 0) begin
          pend_wr[i]   = 1'b1;
          wr_addr_m[i] = A'($urandom);
          wr_data_m[i] = D'($urandom);
        end
      end
      drive_consumers();
      serve_one(int'($urandom_range(4, 1)), int'($urandom_range(3)),
                $urandom_range(4) == 0, -1, -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
